// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage register file.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-through on reads).
package wb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;
    localparam int CNT_W    = 16;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/wb_mux.sv
// Writeback source select: load data or ALU result.
// Part of wb_regfile (optional macro WB_BYPASS_EN handled in the top).
module wb_mux #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data_mem,
    input  logic              sel,
    output logic [DATA_W-1:0] wb_data
);

    import wb_pkg::*;

    always_comb begin
        wb_data = alu_result;
        if (sel == WB_SEL_MEM) begin
            wb_data = read_data_mem;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file with commit counter.
// Define WB_BYPASS_EN to make reads of the register being written return the new value.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] read_data_mem_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [ADDR_W-1:0] mux_rd_rt_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [15:0]       wb_count
);

    import wb_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rs_stored;
    logic [DATA_W-1:0] rt_stored;
    logic [CNT_W-1:0]  count_q;
    logic              wr_req;
    logic              wr_commit;

    wb_mux #(
        .DATA_W(DATA_W)
    ) u_wb_mux (
        .alu_result   (alu_result_in),
        .read_data_mem(read_data_mem_in),
        .sel          (MemToReg_in),
        .wb_data      (wb_data)
    );

    assign wr_req    = RegWrite_in && (mux_rd_rt_in != ZERO_ADDR);
    assign wr_commit = wr_req && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[mux_rd_rt_in] <= wb_data;
        end
    end

    // Counter wraps naturally; no overflow flag is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (wr_commit) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_comb begin
        rs_stored = regs[rs_addr];
        rt_stored = regs[rt_addr];
        if (rs_addr == ZERO_ADDR) begin
            rs_stored = '0;
        end
        if (rt_addr == ZERO_ADDR) begin
            rt_stored = '0;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rs_data = rs_stored;
        rt_data = rt_stored;
        if (wr_req && (rs_addr == mux_rd_rt_in)) begin
            rs_data = wb_data;
        end
        if (wr_req && (rt_addr == mux_rd_rt_in)) begin
            rt_data = wb_data;
        end
    end
`else
    assign rs_data = rs_stored;
    assign rt_data = rt_stored;
`endif

    assign wb_data_out = wb_data;
    assign wb_count    = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed, table-driven bench for wb_regfile.
// Honours WB_BYPASS_EN for the same-cycle read-during-write expectation.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [15:0] read_data_mem_in;
    logic [15:0] alu_result_in;
    logic [2:0]  mux_rd_rt_in;
    logic        MemToReg_in;
    logic        RegWrite_in;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] wb_data_out;
    logic [15:0] wb_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] mem;
        logic [15:0] alu;
        logic [2:0]  rd;
        logic        m2r;
        logic        we;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [15:0] e_rs;
        logic [15:0] e_rt;
        logic [15:0] e_wb;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [7];

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .read_data_mem_in(read_data_mem_in),
        .alu_result_in   (alu_result_in),
        .mux_rd_rt_in    (mux_rd_rt_in),
        .MemToReg_in     (MemToReg_in),
        .RegWrite_in     (RegWrite_in),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .wb_data_out     (wb_data_out),
        .wb_count        (wb_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] mem, input logic [15:0] alu,
                         input logic [2:0] rd, input logic m2r,
                         input logic we, input logic [2:0] rs,
                         input logic [2:0] rt);
        read_data_mem_in = mem;
        alu_result_in    = alu;
        mux_rd_rt_in     = rd;
        MemToReg_in      = m2r;
        RegWrite_in      = we;
        rs_addr          = rs;
        rt_addr          = rt;
    endtask

    initial begin
        logic [15:0] cnt;
        logic [15:0] exp_same;
        int          n;

        // Expected outputs are sampled before the edge that commits the row.
        vecs[0] = '{16'h0000, 16'h1234, 3'd3, 1'b0, 1'b1, 3'd0, 3'd1,
                    16'h0000, 16'h0000, 16'h1234, 16'd0};
        vecs[1] = '{16'hBEEF, 16'h1111, 3'd0, 1'b1, 1'b1, 3'd3, 3'd3,
                    16'h1234, 16'h1234, 16'hBEEF, 16'd1};
        vecs[2] = '{16'h0000, 16'h7777, 3'd4, 1'b0, 1'b0, 3'd0, 3'd3,
                    16'h0000, 16'h1234, 16'h7777, 16'd1};
        vecs[3] = '{16'hCAFE, 16'h0000, 3'd7, 1'b1, 1'b1, 3'd4, 3'd0,
                    16'h0000, 16'h0000, 16'hCAFE, 16'd1};
        vecs[4] = '{16'h0000, 16'hFFFF, 3'd1, 1'b0, 1'b1, 3'd7, 3'd3,
                    16'hCAFE, 16'h1234, 16'hFFFF, 16'd2};
        vecs[5] = '{16'h0001, 16'h0002, 3'd3, 1'b1, 1'b1, 3'd1, 3'd7,
                    16'hFFFF, 16'hCAFE, 16'h0001, 16'd3};
        vecs[6] = '{16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd3, 3'd1,
                    16'h0001, 16'hFFFF, 16'h0000, 16'd4};

        rst = 1'b1;
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 8; a++) begin
            drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 3'(a), 3'(7 - a));
            #2;
            check($sformatf("reset_rs%0d", a), rs_data, 16'h0000);
            check($sformatf("reset_rt%0d", 7 - a), rt_data, 16'h0000);
            @(negedge clk);
        end
        check("reset_cnt", wb_count, 16'd0);

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].mem, vecs[i].alu, vecs[i].rd, vecs[i].m2r,
                  vecs[i].we, vecs[i].rs, vecs[i].rt);
            #2;
            check($sformatf("v%0d_rs", i), rs_data, vecs[i].e_rs);
            check($sformatf("v%0d_rt", i), rt_data, vecs[i].e_rt);
            check($sformatf("v%0d_wb", i), wb_data_out, vecs[i].e_wb);
            check($sformatf("v%0d_cnt", i), wb_count, vecs[i].e_cnt);
            @(negedge clk);
        end
        cnt = 16'd4;

        // Read-during-write on r5.
        drive(16'h0, 16'h0F0F, 3'd5, 1'b0, 1'b1, 3'd0, 3'd0);
        @(negedge clk);
        cnt++;
        drive(16'h0, 16'hA5A5, 3'd5, 1'b0, 1'b1, 3'd5, 3'd5);
`ifdef WB_BYPASS_EN
        exp_same = 16'hA5A5;
`else
        exp_same = 16'h0F0F;
`endif
        #2;
        check("rdw_same_rs", rs_data, exp_same);
        check("rdw_same_rt", rt_data, exp_same);
        @(negedge clk);
        cnt++;
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd5, 3'd5);
        #2;
        check("rdw_next_rs", rs_data, 16'hA5A5);
        check("rdw_next_rt", rt_data, 16'hA5A5);
        check("rdw_cnt", wb_count, cnt);
        @(negedge clk);

        // Drive the counter to 0xFFFF, then wrap it with one more write.
        n = 32'hFFFF - int'(cnt);
        drive(16'h0, 16'h2222, 3'd2, 1'b0, 1'b1, 3'd0, 3'd0);
        repeat (n) @(negedge clk);
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd2, 3'd0);
        #2;
        check("pre_wrap_cnt", wb_count, 16'hFFFF);
        check("pre_wrap_r2", rs_data, 16'h2222);
        @(negedge clk);
        drive(16'h0, 16'h4321, 3'd1, 1'b0, 1'b1, 3'd0, 3'd0);
        @(negedge clk);
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd1, 3'd0);
        #2;
        check("wrap_cnt", wb_count, 16'h0000);
        check("wrap_r1", rs_data, 16'h4321);
        @(negedge clk);

        // Reset together with a write; outputs stay live while rst is high.
        rst = 1'b1;
        drive(16'h0, 16'h5555, 3'd2, 1'b0, 1'b1, 3'd1, 3'd3);
        #2;
        check("inrst_wb", wb_data_out, 16'h5555);
        check("inrst_rs", rs_data, 16'h4321);
        check("inrst_rt", rt_data, 16'h0001);
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd2, 3'd1);
        #2;
        check("rstw_r2", rs_data, 16'h0000);
        check("rstw_r1", rt_data, 16'h0000);
        check("rstw_cnt", wb_count, 16'h0000);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
